comparator_bist_driver: RTL and testbench
=========================================

Name: comparator_bist_driver

Overview:
Synthesizable built-in self-test engine that sits on the input side of the 4-input `comparator` block. It drives every 4-bit input combination onto A/B/C/D and samples `z` after a settle window. It compares `z` against the golden function z = (A==C)&&(B==D), and reports pass/fail, an error count and the first failing vector. The BIST controller instantiates it next to the comparator, so the block can be checked in silicon without a testbench.

Parameters:
- SETTLE_CYCLES, 2, idle cycles between driving a vector and sampling z (legal 0..15).
- ERR_W, 5, width of the saturating error counter (legal 1..8).

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a run when not busy.
- z_in  input  1  comparator output under test.
- a_o, b_o, c_o, d_o  output  1 each  registered stimulus to comparator A, B, C, D.
- busy  output  1  high from the cycle after start is accepted until the run ends.
- done  output  1  high from run end until the next accepted start or reset.
- pass  output  1  valid while done; 1 iff err_cnt==0.
- err_cnt  output  ERR_W  number of mismatches, saturating at 2^ERR_W-1.
- first_fail_vec  output  4  {A,B,C,D} of the first mismatch.
- first_fail_vld  output  1  high once any mismatch has been recorded in the current run.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, vec=0, all outputs 0. Applies at any time, including mid-run; stimulus returns to 0000 immediately.
- Vector ordering: vec counts 0..15; {a_o,b_o,c_o,d_o}=vec, with a_o as the MSB.
- Expected z: exp = (vec[3]==vec[1]) && (vec[2]==vec[0]). It is 1 only for vec 0, 5, 10 and 15.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
  - IDLE/DONE + start=1 → DRIVE. On this transition: vec=0; err_cnt, first_fail_vld and done cleared; busy=1.
  - DRIVE (1 cycle): stimulus registers load vec. Next state is SETTLE if SETTLE_CYCLES>0, else CHECK.
  - SETTLE: the settle counter runs for exactly SETTLE_CYCLES cycles, then → CHECK.
  - CHECK (1 cycle): sample z_in and compare it with exp.
    - On mismatch, err_cnt increments unless it is already saturated.
    - On the first mismatch, first_fail_vec=vec and first_fail_vld=1.
    - If vec==15 → DONE; otherwise vec+1 → DRIVE.
  - DONE: busy=0, done=1, pass=(err_cnt==0). Stimulus holds the last vector (1111).
- Cycles per vector = SETTLE_CYCLES+2. A full run takes 16*(SETTLE_CYCLES+2) cycles from start acceptance to done=1; that is 64 cycles at the defaults.
- start while busy=1 is ignored, with no effect on state or counters. start held high is treated as a pulse per cycle, so it re-triggers only once the block is in IDLE/DONE.
- err_cnt saturates: at 2^ERR_W-1 further mismatches leave it unchanged, and pass stays 0.
- pass and first_fail_vec are don't-care while done=0, but are driven deterministically (not X).

Optional Feature:
- Macro COMPARATOR_BIST_STOP_ON_FAIL_EN.
- Defined: a mismatch in CHECK transitions directly to DONE. err_cnt=1, first_fail_vld=1, and stimulus holds the failing vector for debug.
- Undefined: all 16 vectors are always exercised, as described above.

Decomposition:
- Shared package comparator_bist_pkg contains:
  - state enum type (IDLE, DRIVE, SETTLE, CHECK, DONE);
  - constant NUM_VECTORS=16 and VEC_W=4;
  - function exp_z(vec) implementing the golden equality.
- One natural sub-module, comparator_bist_vecgen: the vector counter plus the exp_z decode (inc/clear inputs, vec/exp/last outputs). The FSM, settle counter and result registers stay in the top.

Test Plan:
- Correct comparator model, defaults, start pulse → done after 64 cycles; pass=1, err_cnt=0, first_fail_vld=0; stimulus sequence 0000..1111 observed.
- z_in stuck at 0 → err_cnt=4, first_fail_vec=0000, pass=0.
- z_in stuck at 1 → err_cnt=12, first_fail_vec=0001. With ERR_W=3 the same run ends with err_cnt=7 (saturated).
- Start pulses every cycle during a run → a single run of exactly 64 cycles. After done, a new start clears done/err_cnt and reruns.
- rst_n low at cycle 30 of a run → outputs 0 immediately and state IDLE. A new start after release runs the full 64 cycles and passes.
- Macro defined, z_in stuck at 0, SETTLE_CYCLES=0 → done 2 cycles after start; err_cnt=1, stimulus and first_fail_vec hold 0000.

Source files
------------

// File: rtl/comparator_bist_pkg.sv
// ---------------------------------------------------------------------------
// comparator_bist_pkg
// Shared definitions for the comparator BIST driver:
//   state_t      - controller states (IDLE, DRIVE, SETTLE, CHECK, DONE)
//   NUM_VECTORS  - number of exhaustive input combinations (16)
//   VEC_W        - width of one stimulus vector {A,B,C,D} (4)
//   exp_z()      - golden comparator function z = (A==C) && (B==D)
// ---------------------------------------------------------------------------
package comparator_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam int NUM_VECTORS = 16;
  localparam int VEC_W       = 4;

  // Vector layout is {A,B,C,D} with A as the MSB.
  function automatic logic exp_z(input logic [VEC_W-1:0] vec);
    return (vec[3] == vec[1]) && (vec[2] == vec[0]);
  endfunction

endpackage

// File: rtl/comparator_bist_vecgen.sv
// ---------------------------------------------------------------------------
// comparator_bist_vecgen
// Vector counter for the comparator BIST plus the golden-z decode.
// Ports:
//   clk, rst_n  - clock / asynchronous active-low reset
//   clear       - restart the sequence at vector 0 (wins over inc)
//   inc         - advance to the next vector
//   vec         - current vector {A,B,C,D}
//   exp         - expected comparator output for vec
//   last        - vec is the final vector of the sequence
// ---------------------------------------------------------------------------
module comparator_bist_vecgen
  import comparator_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [VEC_W-1:0] vec,
  output logic             exp,
  output logic             last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec <= '0;
    end else if (clear) begin
      vec <= '0;
    end else if (inc) begin
      vec <= vec + 1'b1;
    end
  end

  assign exp  = exp_z(vec);
  assign last = (vec == VEC_W'(NUM_VECTORS - 1));

endmodule

// File: rtl/comparator_bist_driver.sv
// ---------------------------------------------------------------------------
// comparator_bist_driver
// Exhaustive self-test engine for the 4-input equality comparator. Drives
// every {A,B,C,D} combination, waits SETTLE_CYCLES, samples z_in and checks
// it against (A==C)&&(B==D).
// Parameters:
//   SETTLE_CYCLES - idle cycles between driving a vector and sampling z (0..15)
//   ERR_W         - width of the saturating error counter (1..8)
// Ports:
//   clk, rst_n       - clock / asynchronous active-low reset
//   start            - begins a run when idle or done
//   z_in             - comparator output under test
//   a_o..d_o         - registered stimulus to comparator inputs A..D
//   busy, done       - run in progress / run finished
//   pass             - no mismatches seen (valid while done)
//   err_cnt          - saturating mismatch count
//   first_fail_vec   - {A,B,C,D} of the first mismatch
//   first_fail_vld   - a mismatch has been recorded in this run
// Build option:
//   COMPARATOR_BIST_STOP_ON_FAIL_EN - end the run at the first mismatch and
//   hold the failing vector on the stimulus outputs.
// ---------------------------------------------------------------------------
module comparator_bist_driver
  import comparator_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             z_in,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  output logic             d_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_vld
);

  // Last settle count value; unused when SETTLE_CYCLES is 0 since SETTLE is skipped.
  localparam logic [3:0]       SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t           state;
  state_t           next_state;
  logic [3:0]       settle_cnt;
  logic [VEC_W-1:0] vec;
  logic             exp;
  logic             last;
  logic             load_stim;
  logic             check_en;
  logic             start_ok;
  logic             mismatch;
  logic             vec_inc;

  comparator_bist_vecgen u_vecgen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_ok),
    .inc   (vec_inc),
    .vec   (vec),
    .exp   (exp),
    .last  (last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = DRIVE;
      DRIVE:      next_state = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
      SETTLE:     if (settle_cnt == SETTLE_LAST) next_state = CHECK;
      CHECK: begin
`ifdef COMPARATOR_BIST_STOP_ON_FAIL_EN
        if ((z_in != exp) || last) next_state = DONE;
        else                       next_state = DRIVE;
`else
        if (last) next_state = DONE;
        else      next_state = DRIVE;
`endif
      end
      default:    next_state = IDLE;
    endcase
  end

  // Output / control decode from the current state
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    load_stim = 1'b0;
    check_en  = 1'b0;
    case (state)
      DRIVE: begin
        busy      = 1'b1;
        load_stim = 1'b1;
      end
      SETTLE: busy = 1'b1;
      CHECK: begin
        busy     = 1'b1;
        check_en = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign mismatch = check_en && (z_in != exp);
  // Advance only when another vector follows; on the way to DONE the counter
  // keeps pointing at the vector still held on the stimulus outputs.
  assign vec_inc  = check_en && (next_state == DRIVE);
  assign pass     = done && (err_cnt == '0);

  // Settle counter: free-runs only inside SETTLE, parked at zero otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (state == SETTLE) begin
      settle_cnt <= settle_cnt + 1'b1;
    end else begin
      settle_cnt <= '0;
    end
  end

  // Stimulus registers feeding the comparator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {a_o, b_o, c_o, d_o} <= '0;
    end else if (load_stim) begin
      {a_o, b_o, c_o, d_o} <= vec;
    end
  end

  // Result registers: cleared by an accepted start, updated on each mismatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt        <= '0;
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
    end else if (start_ok) begin
      err_cnt        <= '0;
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
    end else if (mismatch) begin
      if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
      if (!first_fail_vld) begin
        first_fail_vec <= vec;
        first_fail_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_comparator_bist_driver.sv
// ---------------------------------------------------------------------------
// tb_comparator_bist_driver
// Self-checking bench for comparator_bist_driver. Three instances share
// rst_n and the comparator fault model: main (defaults), sat (ERR_W=3,
// started together with main) and fast (SETTLE_CYCLES=0, own start).
// ---------------------------------------------------------------------------
module tb_comparator_bist_driver;

  localparam int S = 2;
`ifdef COMPARATOR_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start_fast = 1'b0;
  int          mode = 0;
  logic [15:0] mask = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic       z_m, z_s, z_f;
  wire  [3:0] stim_m, stim_s, stim_f;
  logic       busy_m, done_m, pass_m, vld_m;
  logic       busy_s, done_s, pass_s, vld_s;
  logic       busy_f, done_f, pass_f, vld_f;
  logic [4:0] err_m, err_f;
  logic [2:0] err_s;
  logic [3:0] ffv_m, ffv_s, ffv_f;

  always #5 clk = ~clk;

  // Golden comparator behaviour
  function automatic logic golden(input int v);
    return (((v >> 3) & 1) == ((v >> 1) & 1)) && (((v >> 2) & 1) == (v & 1));
  endfunction

  // Comparator under test: 1 = stuck at 0, 2 = stuck at 1, else golden with mask faults
  function automatic logic drive_z(input int md, input logic [15:0] mk, input int v);
    case (md)
      1:       return 1'b0;
      2:       return 1'b1;
      default: return golden(v) ^ mk[v];
    endcase
  endfunction

  always_comb z_m = drive_z(mode, mask, int'(stim_m));
  always_comb z_s = drive_z(mode, mask, int'(stim_s));
  always_comb z_f = drive_z(mode, mask, int'(stim_f));

  comparator_bist_driver #(.SETTLE_CYCLES(S), .ERR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .z_in(z_m),
    .a_o(stim_m[3]), .b_o(stim_m[2]), .c_o(stim_m[1]), .d_o(stim_m[0]),
    .busy(busy_m), .done(done_m), .pass(pass_m), .err_cnt(err_m),
    .first_fail_vec(ffv_m), .first_fail_vld(vld_m));

  comparator_bist_driver #(.SETTLE_CYCLES(S), .ERR_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .z_in(z_s),
    .a_o(stim_s[3]), .b_o(stim_s[2]), .c_o(stim_s[1]), .d_o(stim_s[0]),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_s),
    .first_fail_vec(ffv_s), .first_fail_vld(vld_s));

  comparator_bist_driver #(.SETTLE_CYCLES(0), .ERR_W(5)) dut_fast (
    .clk(clk), .rst_n(rst_n), .start(start_fast), .z_in(z_f),
    .a_o(stim_f[3]), .b_o(stim_f[2]), .c_o(stim_f[1]), .d_o(stim_f[0]),
    .busy(busy_f), .done(done_f), .pass(pass_f), .err_cnt(err_f),
    .first_fail_vec(ffv_f), .first_fail_vld(vld_f));

  // Reference model: walk all vectors, count mismatches, note the first one
  task automatic model(input int md, input logic [15:0] mk,
                       output int nerr, output int first, output int nvec);
    nerr = 0; first = -1; nvec = 16;
    for (int v = 0; v < 16; v++) begin
      if (drive_z(md, mk, v) != golden(v)) begin
        if (first < 0) first = v;
        nerr++;
        if (STOP) begin
          nvec = v + 1;
          break;
        end
      end
    end
  endtask

  // Pulse (or hold) start on main/sat, count cycles to done, watch stimulus order
  task automatic run_main(input bit hold, output int cycles, output bit stim_ok,
                          output bit clr_ok);
    stim_ok = 1'b1; cycles = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    clr_ok = (busy_m === 1'b1) && (done_m === 1'b0) && (err_m === 5'd0) && (vld_m === 1'b0);
    for (int k = 0; k <= 400; k++) begin
      if (done_m === 1'b1) begin
        cycles = k;
        break;
      end
      if (k >= 1 && (k - 1) % (S + 2) == 0)
        if (stim_m !== 4'((k - 1) / (S + 2))) stim_ok = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic run_fast(output int cycles);
    cycles = -1;
    @(posedge clk); #1 start_fast = 1'b1;
    @(posedge clk); #1 start_fast = 1'b0;
    for (int k = 0; k <= 200; k++) begin
      if (done_f === 1'b1) begin
        cycles = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({stim_m, busy_m, done_m, pass_m, err_m, ffv_m, vld_m} !== 18'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_main got %h want 0", {stim_m, busy_m, done_m, pass_m, err_m, ffv_m, vld_m});
    end
    n_checks++;
    if ({stim_s, busy_s, done_s, pass_s, err_s, ffv_s, vld_s} !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_sat got %h want 0", {stim_s, busy_s, done_s, pass_s, err_s, ffv_s, vld_s});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  // One full run with the current fault model, checked against the reference
  task automatic check_run(input string name, input bit hold);
    int cycles, nerr, first, nvec;
    bit stim_ok, clr_ok;
    logic [3:0] hold_vec;
    model(mode, mask, nerr, first, nvec);
    run_main(hold, cycles, stim_ok, clr_ok);
    hold_vec = (STOP && first >= 0) ? 4'(first) : 4'hF;
    n_checks++;
    if (cycles != nvec * (S + 2)) begin
      n_fail++; $display("[TB] FAIL %s cycles got %0d want %0d", name, cycles, nvec * (S + 2));
    end
    n_checks++;
    if (!stim_ok || !clr_ok) begin
      n_fail++; $display("[TB] FAIL %s stim_seq/start_clear got %0d%0d want 11", name, stim_ok, clr_ok);
    end
    n_checks++;
    if (err_m !== 5'(STOP ? (nerr > 0 ? 1 : 0) : nerr)) begin
      n_fail++; $display("[TB] FAIL %s err_cnt got %0d want %0d", name, err_m, STOP ? (nerr > 0) : nerr);
    end
    n_checks++;
    if (err_s !== 3'(STOP ? (nerr > 0 ? 1 : 0) : (nerr > 7 ? 7 : nerr))) begin
      n_fail++; $display("[TB] FAIL %s err_sat got %0d want %0d", name, err_s, nerr > 7 ? 7 : nerr);
    end
    n_checks++;
    if ({pass_m, vld_m, busy_m} !== {nerr == 0, first >= 0, 1'b0}) begin
      n_fail++; $display("[TB] FAIL %s pass/vld/busy got %b%b%b want %b%b0", name, pass_m, vld_m, busy_m, nerr == 0, first >= 0);
    end
    n_checks++;
    if (stim_m !== hold_vec) begin
      n_fail++; $display("[TB] FAIL %s stim_hold got %h want %h", name, stim_m, hold_vec);
    end
    if (first >= 0) begin
      n_checks++;
      if (ffv_m !== 4'(first)) begin
        n_fail++; $display("[TB] FAIL %s first_fail_vec got %h want %h", name, ffv_m, 4'(first));
      end
    end
  endtask

  task automatic test_golden();
    mode = 0; mask = '0;
    check_run("golden", 1'b0);
  endtask

  task automatic test_stuck();
    mode = 1; check_run("stuck0", 1'b0);
    mode = 2; check_run("stuck1", 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      mode = 0;
      mask = 16'($urandom);
      check_run("random", 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    mode = 0; mask = '0;
    check_run("start_held", 1'b1);
    mode = 1;
    check_run("rerun_fail", 1'b0);
    mode = 0;
    check_run("rerun_clear", 1'b0);
  endtask

  task automatic test_reset_mid_run();
    mode = 0; mask = '0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({stim_m, busy_m, done_m, pass_m, err_m, ffv_m, vld_m} !== 18'd0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset got %h want 0", {stim_m, busy_m, done_m, pass_m, err_m, ffv_m, vld_m});
    end
    @(negedge clk) rst_n = 1'b1;
    check_run("after_reset", 1'b0);
  endtask

  task automatic test_zero_settle();
    int cycles, nerr, first, nvec;
    mode = 1;
    model(mode, mask, nerr, first, nvec);
    run_fast(cycles);
    n_checks++;
    if (cycles != nvec * 2) begin
      n_fail++; $display("[TB] FAIL zero_settle cycles got %0d want %0d", cycles, nvec * 2);
    end
    n_checks++;
    if (err_f !== 5'(STOP ? 1 : nerr)) begin
      n_fail++; $display("[TB] FAIL zero_settle err_cnt got %0d want %0d", err_f, STOP ? 1 : nerr);
    end
    n_checks++;
    if ({ffv_f, vld_f, pass_f} !== {4'(first), 1'b1, 1'b0}) begin
      n_fail++; $display("[TB] FAIL zero_settle ffv/vld/pass got %h%b%b want %h10", ffv_f, vld_f, pass_f, 4'(first));
    end
    n_checks++;
    if (stim_f !== (STOP ? 4'(first) : 4'hF)) begin
      n_fail++; $display("[TB] FAIL zero_settle stim_hold got %h want %h", stim_f, STOP ? 4'(first) : 4'hF);
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_stuck();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_zero_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
